// File: rtl/mac_operand_feeder.sv
// Operand sequencer for the 9-lane MAC datapath: stages beats, owns the saturated
// pre_output feedback and buffers finished results. Optional macro: MAC_FEEDER_SATCNT_EN.
module mac_operand_feeder #(
  parameter int PASSES = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [71:0] in_act,
  input  logic [71:0] in_wgt,
  input  logic [15:0] in_bias,
  output logic [71:0] mac_a,
  output logic [71:0] mac_b,
  output logic [15:0] mac_bias,
  output logic [12:0] mac_pre,
  input  logic [13:0] mac_out,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [12:0] out_data,
  output logic        out_sat,
  output logic        busy
`ifdef MAC_FEEDER_SATCNT_EN
  ,
  output logic [15:0] sat_count
`endif
);

  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;

  typedef enum logic {IDLE, RUN} state_e;

  typedef struct packed {
    logic [12:0] data;
    logic        sat;
  } result_t;

  state_e        state_q, state_d;
  logic          stage_v;
  logic          accept;
  logic [71:0]   mac_a_q, mac_b_q;
  logic [15:0]   mac_bias_q;
  logic [PW-1:0] pcnt_q;
  logic          stage_last_q;
  logic [12:0]   pre_q;
  logic          sat_acc_q;
  logic [12:0]   sat_val;
  logic          sat_hit;
  logic          push, pop;
  result_t       fifo_q [2];
  logic          wr_ptr_q, rd_ptr_q;
  logic [1:0]    count_q;

  assign accept = in_valid & in_ready;

  // FSM: state register
  always_ff @(posedge clk) begin
    // NOTE: sequential state always uses non-blocking assignment so every flop
    // samples pre-edge values regardless of process ordering.
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    // NOTE: defaulting every combinational output first prevents latch inference.
    state_d = state_q;
    case (state_q)
      IDLE: if (accept)  state_d = RUN;
      RUN:  if (!accept) state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    stage_v = (state_q == RUN);
  end

  // Stage register and pass counter; bias only enters on the first pass of a group
  always_ff @(posedge clk) begin
    if (!reset) begin
      mac_a_q      <= '0;
      mac_b_q      <= '0;
      mac_bias_q   <= '0;
      pcnt_q       <= '0;
      stage_last_q <= 1'b0;
    end else if (accept) begin
      mac_a_q      <= in_act;
      mac_b_q      <= in_wgt;
      mac_bias_q   <= (pcnt_q == '0) ? in_bias : '0;
      stage_last_q <= (pcnt_q == PW'(PASSES - 1));
      pcnt_q       <= (pcnt_q == PW'(PASSES - 1)) ? '0 : pcnt_q + PW'(1);
    end
  end

  // Clamp the 14-bit datapath result into 13-bit signed range
  always_comb begin
    sat_hit = mac_out[13] ^ mac_out[12];
    case (mac_out[13:12])
      2'b01:   sat_val = 13'h0FFF;
      2'b10:   sat_val = 13'h1000;
      default: sat_val = mac_out[12:0];
    endcase
  end

  assign push = stage_v & stage_last_q;
  assign pop  = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_q     <= '0;
      sat_acc_q <= 1'b0;
    end else if (stage_v) begin
      if (stage_last_q) begin
        pre_q     <= '0;
        sat_acc_q <= 1'b0;
      end else begin
        pre_q     <= sat_val;
        sat_acc_q <= sat_acc_q | sat_hit;
      end
    end
  end

  // Two-entry result FIFO; push into a full FIFO only happens alongside a pop
  always_ff @(posedge clk) begin
    if (!reset) begin
      // NOTE: the storage is tiny and out_data must read 0 after reset, so it is
      // reset here; larger memories would normally be left unreset.
      for (int i = 0; i < 2; i++) fifo_q[i] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= '{data: sat_val, sat: sat_acc_q | sat_hit};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Reserve a FIFO slot for a staged final beat so no result can be dropped
  assign in_ready  = reset & (({1'b0, count_q} + {2'b00, push}) < 3'd2);
  assign out_valid = (count_q != '0);
  assign out_data  = fifo_q[rd_ptr_q].data;
  assign out_sat   = fifo_q[rd_ptr_q].sat;
  assign mac_a     = mac_a_q;
  assign mac_b     = mac_b_q;
  assign mac_bias  = mac_bias_q;
  assign mac_pre   = pre_q;
  assign busy      = stage_v | (pcnt_q != '0) | (pre_q != '0);

`ifdef MAC_FEEDER_SATCNT_EN
  logic [15:0] sat_cnt_q;

  always_ff @(posedge clk) begin
    if (!reset)                                         sat_cnt_q <= '0;
    else if (stage_v && sat_hit && sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_mac_operand_feeder.sv
// Scoreboard bench for mac_operand_feeder with a behavioural model of the MAC datapath
// and a group-level accumulation reference model.
module tb_mac_operand_feeder;

  localparam int PASSES = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [71:0] in_act, in_wgt;
  logic [15:0] in_bias;
  logic [71:0] mac_a, mac_b;
  logic [15:0] mac_bias;
  logic [12:0] mac_pre;
  logic [13:0] mac_out;
  logic        out_valid;
  logic        out_ready;
  logic [12:0] out_data;
  logic        out_sat;
  logic        busy;
`ifdef MAC_FEEDER_SATCNT_EN
  logic [15:0] sat_count;
`endif

  always #5 clk = ~clk;

  mac_operand_feeder #(.PASSES(PASSES)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_act    (in_act),
    .in_wgt    (in_wgt),
    .in_bias   (in_bias),
    .mac_a     (mac_a),
    .mac_b     (mac_b),
    .mac_bias  (mac_bias),
    .mac_pre   (mac_pre),
    .mac_out   (mac_out),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_sat   (out_sat),
    .busy      (busy)
`ifdef MAC_FEEDER_SATCNT_EN
    ,
    .sat_count (sat_count)
`endif
  );

  // Datapath: 9 products + bias + (pre << 6), raw sum bits [19:6]
  int dp_sum;
  always_comb begin
    dp_sum = 0;
    for (int k = 0; k < 9; k++)
      dp_sum = dp_sum + int'($signed(mac_a[8*k +: 8])) * int'($signed(mac_b[8*k +: 8]));
    dp_sum  = dp_sum + int'($signed(mac_bias)) + int'($signed(mac_pre)) * 64;
    mac_out = dp_sum[19:6];
  end

  typedef struct {
    int data;
    bit sat;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   m_pass = 0;
  int   m_acc  = 0;
  bit   m_sat  = 0;
  int   m_satcnt = 0;
  bit   stim_done;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic int lane_dot(input logic [71:0] a, input logic [71:0] w);
    int acc = 0;
    for (int k = 0; k < 9; k++)
      acc += int'($signed(a[8*k +: 8])) * int'($signed(w[8*k +: 8]));
    return acc;
  endfunction

  // Reference: one group = PASSES beats folded through a clamped feedback value
  task automatic model_beat(input logic [71:0] act, input logic [71:0] wgt, input logic [15:0] bias);
    int s, r;
    bit sat;
    s = lane_dot(act, wgt) + ((m_pass == 0) ? int'($signed(bias)) : 0) + m_acc * 64;
    r = s >>> 6;
    sat = 0;
    if (r > 4095)       begin r = 4095;  sat = 1; end
    else if (r < -4096) begin r = -4096; sat = 1; end
    if (sat && m_satcnt < 65535) m_satcnt++;
    m_sat |= sat;
    if (m_pass == PASSES - 1) begin
      exp_q.push_back('{data: r, sat: m_sat});
      m_pass = 0;
      m_acc  = 0;
      m_sat  = 0;
    end else begin
      m_acc = r;
      m_pass++;
    end
  endtask

  task automatic send(input logic [71:0] act, input logic [71:0] wgt, input logic [15:0] bias);
    bit ok, done;
    int waited;
    logic [12:0] ep;
    logic [15:0] eb;
    in_valid = 1'b1;
    in_act   = act;
    in_wgt   = wgt;
    in_bias  = bias;
    done     = 0;
    waited   = 0;
    while (!done) begin
      ok = in_ready;
      @(posedge clk);
      #1;
      if (ok) done = 1;
      else if (++waited > 200) begin
        check("accept_timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
    end
    in_valid = 1'b0;
    ep = m_acc[12:0];
    eb = (m_pass == 0) ? bias : 16'h0000;
    check("mac_a", 32'(mac_a == act), 1);
    check("mac_b", 32'(mac_b == wgt), 1);
    check("mac_bias", {16'b0, mac_bias}, {16'b0, eb});
    check("mac_pre", {19'b0, mac_pre}, {19'b0, ep});
    model_beat(act, wgt, bias);
  endtask

  task automatic send_rand();
    logic [95:0] ra, rw;
    ra = {$urandom(), $urandom(), $urandom()};
    rw = {$urandom(), $urandom(), $urandom()};
    send(ra[71:0], rw[71:0], 16'($urandom()));
  endtask

  // Uniform group with explicit latency and result checks; FIFO must be empty and out_ready high
  task automatic uniform_group(input logic [7:0] a8, input logic [7:0] w8, input logic [15:0] bias,
                               input logic [12:0] exp_data, input logic exp_sat);
    for (int p = 0; p < PASSES; p++) send({9{a8}}, {9{w8}}, bias);
    check("lat_valid_n", 32'(out_valid), 0);
    @(posedge clk); #1;
    check("lat_valid_n1", 32'(out_valid), 1);
    check("grp_data", {19'b0, out_data}, {19'b0, exp_data});
    check("grp_sat", 32'(out_sat), 32'(exp_sat));
    @(posedge clk); #1;
    check("valid_one_cycle", 32'(out_valid), 0);
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  // Monitor: pop one expected result per output handshake
  always @(negedge clk) begin
    exp_t e;
    if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) check("unexpected_result", 1, 0);
      else begin
        e = exp_q.pop_front();
        check("out_data", {19'b0, out_data}, {19'b0, e.data[12:0]});
        check("out_sat", 32'(out_sat), 32'(e.sat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_act    = '0;
    in_wgt    = '0;
    in_bias   = '0;
    out_ready = 1'b1;
    stim_done = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 0);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_sat", 32'(out_sat), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_mac_a", 32'(mac_a == 72'h0), 1);
    check("rst_mac_b", 32'(mac_b == 72'h0), 1);
    check("rst_mac_bias", {16'b0, mac_bias}, 0);
    check("rst_mac_pre", {19'b0, mac_pre}, 0);
    check("rst_out_data", {19'b0, out_data}, 0);
    reset = 1'b1;
    #1;
    check("in_ready_after_reset", 32'(in_ready), 1);

    uniform_group(8'h40, 8'h40, 16'h0000, 13'h0900, 1'b0);
    uniform_group(8'h7F, 8'h7F, 16'h0000, 13'h0FFF, 1'b1);
    uniform_group(8'h80, 8'h7F, 16'h0000, 13'h1000, 1'b1);
    uniform_group(8'h00, 8'h00, 16'h0040, 13'h0001, 1'b0);
    drain();

    // Back-pressure: three groups against a stalled consumer
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3 * PASSES; i++) send_rand();
      end
      begin
        repeat (25) @(posedge clk);
        #2;
        check("bp_in_ready_low", 32'(in_ready), 0);
        check("bp_out_valid", 32'(out_valid), 1);
        check("bp_pending", exp_q.size(), 2);
        out_ready = 1'b1;
      end
    join
    drain();

    // Random beats, random gaps, random consumer stalls
    fork
      begin
        for (int i = 0; i < 10 * PASSES; i++) begin
          send_rand();
          repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
        end
        stim_done = 1;
      end
      begin
        while (!stim_done) begin
          @(posedge clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    // Reset in the middle of a group
    send_rand();
    send_rand();
    reset = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_mac_pre", {19'b0, mac_pre}, 0);
    check("mid_rst_mac_a", 32'(mac_a == 72'h0), 1);
    check("mid_rst_mac_bias", {16'b0, mac_bias}, 0);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_in_ready", 32'(in_ready), 0);
    reset    = 1'b1;
    m_pass   = 0;
    m_acc    = 0;
    m_sat    = 0;
    m_satcnt = 0;
    #1;
    check("mid_rst_ready_back", 32'(in_ready), 1);
    uniform_group(8'h40, 8'h40, 16'h0000, 13'h0900, 1'b0);
    drain();
    check("idle_busy", 32'(busy), 0);
`ifdef MAC_FEEDER_SATCNT_EN
    check("sat_count", {16'b0, sat_count}, 32'(m_satcnt));
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
